// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// LOADER_CHECKSUM_EN adds the CHK state used by the trailing XOR checksum byte.
package loader_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int HDR_BYTES      = 2;
  localparam int ADDR_W_DEFAULT = 11;

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    ST_IDLE, ST_HDR_LO, ST_HDR_HI, ST_DATA, ST_WR, ST_CHK, ST_DONE, ST_ERR
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE, ST_HDR_LO, ST_HDR_HI, ST_DATA, ST_WR, ST_DONE, ST_ERR
  } state_t;
`endif

endpackage

// File: rtl/imem_boot_loader_byte_packer.sv
// Byte packer: shifts bytes in from the top so the first byte lands in bits [7:0].
// word_full flags the transfer that completes a 4-byte word; word_next is the packed result.
import loader_pkg::*;

module byte_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        shift_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word_next,
  output logic        word_full
);

  logic [31:0] word;
  logic [1:0]  idx;

  assign word_next = {byte_in, word[31:8]};
  assign word_full = shift_en && (idx == 2'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word <= '0;
      idx  <= '0;
    end else if (clear) begin
      word <= '0;
      idx  <= '0;
    end else if (shift_en) begin
      word <= word_next;
      idx  <= idx + 2'd1;
    end
  end

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: header-prefixed UART byte stream -> sequential 32-bit memory writes, core held until done.
// Optional trailing XOR checksum byte when LOADER_CHECKSUM_EN is defined.
import loader_pkg::*;

module imem_boot_loader #(
  parameter int ADDR_W    = ADDR_W_DEFAULT,
  parameter int DATA_W    = 32,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [ADDR_W-1:0] mem_a,
  output logic [DATA_W-1:0] mem_d,
  output logic              mem_we,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              cpu_run,
  output logic [ADDR_W:0]   word_cnt
);

  state_t      state;
  logic [15:0] num_words;
  logic        xfer;
  logic        idle_like;
  logic        pk_clear;
  logic        pk_shift;
  logic [31:0] pk_word;
  logic        pk_full;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  csum;
`endif

  assign xfer      = rx_valid && rx_ready;
  assign idle_like = (state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR);
  assign pk_clear  = start && idle_like;
  assign pk_shift  = xfer && (state == ST_DATA);

  byte_packer u_packer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (pk_clear),
    .shift_en  (pk_shift),
    .byte_in   (rx_data),
    .word_next (pk_word),
    .word_full (pk_full)
  );

  // All status outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      num_words <= '0;
      word_cnt  <= '0;
      mem_a     <= '0;
      mem_d     <= '0;
      mem_we    <= 1'b0;
      rx_ready  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      cpu_run   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum      <= '0;
`endif
    end else begin
      state_t      nxt;
      logic [15:0] hdr;
      nxt    = state;
      hdr    = {rx_data, num_words[7:0]};
      mem_we <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start) begin
            nxt      = ST_HDR_LO;
            word_cnt <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum     <= '0;
`endif
          end
        end
        ST_HDR_LO: begin
          if (xfer) begin
            num_words[7:0] <= rx_data;
            nxt            = ST_HDR_HI;
          end
        end
        ST_HDR_HI: begin
          if (xfer) begin
            num_words[15:8] <= rx_data;
            if (hdr == 16'd0)
              nxt = ST_DONE;
            else if (32'(hdr) > (32'd1 << ADDR_W))
              nxt = ST_ERR;
            else
              nxt = ST_DATA;
          end
        end
        ST_DATA: begin
          if (xfer) begin
`ifdef LOADER_CHECKSUM_EN
            csum <= csum ^ rx_data;
`endif
            if (pk_full) begin
              nxt    = ST_WR;
              mem_we <= 1'b1;
              mem_a  <= ADDR_W'(BASE_ADDR) + word_cnt[ADDR_W-1:0];
              mem_d  <= DATA_W'(pk_word);
            end
          end
        end
        ST_WR: begin
          word_cnt <= word_cnt + 1'b1;
          if ((32'(word_cnt) + 32'd1) == 32'(num_words)) begin
`ifdef LOADER_CHECKSUM_EN
            nxt = ST_CHK;
`else
            nxt = ST_DONE;
`endif
          end else begin
            nxt = ST_DATA;
          end
        end
`ifdef LOADER_CHECKSUM_EN
        ST_CHK: begin
          if (xfer)
            nxt = (rx_data == csum) ? ST_DONE : ST_ERR;
        end
`endif
        default: nxt = ST_IDLE;
      endcase
      state    <= nxt;
`ifdef LOADER_CHECKSUM_EN
      rx_ready <= (nxt == ST_HDR_LO) || (nxt == ST_HDR_HI) || (nxt == ST_DATA) || (nxt == ST_CHK);
      busy     <= (nxt == ST_HDR_LO) || (nxt == ST_HDR_HI) || (nxt == ST_DATA) ||
                  (nxt == ST_WR) || (nxt == ST_CHK);
`else
      rx_ready <= (nxt == ST_HDR_LO) || (nxt == ST_HDR_HI) || (nxt == ST_DATA);
      busy     <= (nxt == ST_HDR_LO) || (nxt == ST_HDR_HI) || (nxt == ST_DATA) || (nxt == ST_WR);
`endif
      done     <= (nxt == ST_DONE);
      cpu_run  <= (nxt == ST_DONE);
      err      <= (nxt == ST_ERR);
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: two instances (BASE_ADDR 0 and 2047) share one byte stream.
// Checksum scenario is compiled in only with LOADER_CHECKSUM_EN.
module tb_imem_boot_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;

  logic        rx_ready0, mem_we0, busy0, done0, err0, cpu_run0;
  logic [10:0] mem_a0;
  logic [31:0] mem_d0;
  logic [11:0] word_cnt0;
  logic        rx_ready1, mem_we1, busy1, done1, err1, cpu_run1;
  logic [10:0] mem_a1;
  logic [31:0] mem_d1;
  logic [11:0] word_cnt1;

  int          tests = 0;
  int          fails = 0;
  int          we_cnt0 = 0;
  int          we_cnt1 = 0;
  logic [7:0]  tb_chk = 8'h00;

  imem_boot_loader #(.ADDR_W(11), .DATA_W(32), .BASE_ADDR(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready0), .mem_a(mem_a0), .mem_d(mem_d0), .mem_we(mem_we0),
    .busy(busy0), .done(done0), .err(err0), .cpu_run(cpu_run0), .word_cnt(word_cnt0)
  );

  imem_boot_loader #(.ADDR_W(11), .DATA_W(32), .BASE_ADDR(2047)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready1), .mem_a(mem_a1), .mem_d(mem_d1), .mem_we(mem_we1),
    .busy(busy1), .done(done1), .err(err1), .cpu_run(cpu_run1), .word_cnt(word_cnt1)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_we0) we_cnt0++;
    if (mem_we1) we_cnt1++;
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    n = 0;
    while (rx_ready0 !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (rx_ready0 !== 1'b1) begin
      tests++;
      fails++;
      $display("[TB] FAIL handshake_timeout byte=%h rx_ready=%b required 1", b, rx_ready0);
      rx_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_hdr(input logic [15:0] n, input int gap);
    send_byte(n[7:0], gap);
    send_byte(n[15:8], gap);
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int k = 0; k < 4; k++) begin
      tb_chk = tb_chk ^ w[8*k +: 8];
      send_byte(w[8*k +: 8], gap);
    end
  endtask

  task automatic send_chk();
`ifdef LOADER_CHECKSUM_EN
    send_byte(tb_chk, 0);
`endif
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start  = 1'b1;
    tb_chk = 8'h00;
    @(negedge clk);
    start  = 1'b0;
  endtask

  task automatic wait_finish();
    int n;
    n = 0;
    while (!(done0 || err0) && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    tests++;
    if ({rx_ready0, mem_we0, busy0, done0, err0, cpu_run0} !== 6'b0) begin
      fails++;
      $display("[TB] FAIL reset_flags0 got=%b required 000000",
               {rx_ready0, mem_we0, busy0, done0, err0, cpu_run0});
    end
    tests++;
    if ({mem_a0, mem_d0, word_cnt0} !== 55'b0) begin
      fails++;
      $display("[TB] FAIL reset_regs0 a=%h d=%h cnt=%0d required 0", mem_a0, mem_d0, word_cnt0);
    end
    tests++;
    if ({rx_ready1, mem_we1, busy1, done1, err1, cpu_run1, mem_a1, mem_d1, word_cnt1} !== 61'b0) begin
      fails++;
      $display("[TB] FAIL reset_dut1 a=%h d=%h cnt=%0d busy=%b required all 0",
               mem_a1, mem_d1, word_cnt1, busy1);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic_load();
    int we0;
    we0 = we_cnt0;
    pulse_start();
    tests++;
    if (busy0 !== 1'b1 || rx_ready0 !== 1'b1) begin
      fails++;
      $display("[TB] FAIL basic_armed busy=%b rx_ready=%b required 1 1", busy0, rx_ready0);
    end
    send_hdr(16'h0002, 0);
    send_word(32'h12345678, 0);
    tests++;
    if (mem_we0 !== 1'b1 || mem_a0 !== 11'd0 || mem_d0 !== 32'h12345678 || rx_ready0 !== 1'b0) begin
      fails++;
      $display("[TB] FAIL basic_word0 we=%b a=%0d d=%h rdy=%b required 1 0 12345678 0",
               mem_we0, mem_a0, mem_d0, rx_ready0);
    end
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    tests++;
    if (busy0 !== 1'b1 || word_cnt0 !== 12'd1 || rx_ready0 !== 1'b1) begin
      fails++;
      $display("[TB] FAIL start_while_busy busy=%b cnt=%0d rdy=%b required 1 1 1",
               busy0, word_cnt0, rx_ready0);
    end
    send_word(32'hDEADBEEF, 0);
    tests++;
    if (mem_we0 !== 1'b1 || mem_a0 !== 11'd1 || mem_d0 !== 32'hDEADBEEF) begin
      fails++;
      $display("[TB] FAIL basic_word1 we=%b a=%0d d=%h required 1 1 deadbeef", mem_we0, mem_a0, mem_d0);
    end
    send_chk();
    wait_finish();
    tests++;
    if (done0 !== 1'b1 || cpu_run0 !== 1'b1 || busy0 !== 1'b0 || err0 !== 1'b0 || word_cnt0 !== 12'd2) begin
      fails++;
      $display("[TB] FAIL basic_done done=%b run=%b busy=%b err=%b cnt=%0d required 1 1 0 0 2",
               done0, cpu_run0, busy0, err0, word_cnt0);
    end
    tests++;
    if (we_cnt0 - we0 !== 2) begin
      fails++;
      $display("[TB] FAIL basic_we_pulses got=%0d required 2", we_cnt0 - we0);
    end
  endtask

  task automatic test_empty_image();
    int we0;
    we0 = we_cnt0;
    pulse_start();
    tests++;
    if (done0 !== 1'b0 || cpu_run0 !== 1'b0 || word_cnt0 !== 12'd0) begin
      fails++;
      $display("[TB] FAIL restart_clears done=%b run=%b cnt=%0d required 0 0 0", done0, cpu_run0, word_cnt0);
    end
    send_hdr(16'h0000, 0);
    tests++;
    if (done0 !== 1'b1 || cpu_run0 !== 1'b1 || busy0 !== 1'b0) begin
      fails++;
      $display("[TB] FAIL empty_done done=%b run=%b busy=%b required 1 1 0", done0, cpu_run0, busy0);
    end
    repeat (3) @(negedge clk);
    tests++;
    if (we_cnt0 - we0 !== 0) begin
      fails++;
      $display("[TB] FAIL empty_no_writes got=%0d required 0", we_cnt0 - we0);
    end
  endtask

  task automatic test_oversize();
    int we0;
    we0 = we_cnt0;
    pulse_start();
    send_hdr(16'h0801, 0);
    tests++;
    if (err0 !== 1'b1 || cpu_run0 !== 1'b0 || done0 !== 1'b0 || busy0 !== 1'b0) begin
      fails++;
      $display("[TB] FAIL oversize_err err=%b run=%b done=%b busy=%b required 1 0 0 0",
               err0, cpu_run0, done0, busy0);
    end
    repeat (2) @(negedge clk);
    tests++;
    if (we_cnt0 - we0 !== 0) begin
      fails++;
      $display("[TB] FAIL oversize_no_writes got=%0d required 0", we_cnt0 - we0);
    end
    pulse_start();
    tests++;
    if (err0 !== 1'b0 || busy0 !== 1'b1) begin
      fails++;
      $display("[TB] FAIL err_recover err=%b busy=%b required 0 1", err0, busy0);
    end
    send_hdr(16'h0000, 0);
    tests++;
    if (done0 !== 1'b1) begin
      fails++;
      $display("[TB] FAIL err_recover_done done=%b required 1", done0);
    end
  endtask

  task automatic test_wrap_gaps();
    pulse_start();
    send_hdr(16'h0002, 1);
    send_word(32'h11223344, 1);
    tests++;
    if (mem_we1 !== 1'b1 || mem_a1 !== 11'd2047 || mem_d1 !== 32'h11223344 || rx_ready1 !== 1'b0) begin
      fails++;
      $display("[TB] FAIL wrap_word0 we=%b a=%0d d=%h rdy=%b required 1 2047 11223344 0",
               mem_we1, mem_a1, mem_d1, rx_ready1);
    end
    send_word(32'h55667788, 1);
    tests++;
    if (mem_we1 !== 1'b1 || mem_a1 !== 11'd0 || mem_d1 !== 32'h55667788 || rx_ready1 !== 1'b0) begin
      fails++;
      $display("[TB] FAIL wrap_word1 we=%b a=%0d d=%h rdy=%b required 1 0 55667788 0",
               mem_we1, mem_a1, mem_d1, rx_ready1);
    end
    send_chk();
    wait_finish();
    tests++;
    if (done1 !== 1'b1 || cpu_run1 !== 1'b1 || word_cnt1 !== 12'd2) begin
      fails++;
      $display("[TB] FAIL wrap_done done=%b run=%b cnt=%0d required 1 1 2", done1, cpu_run1, word_cnt1);
    end
  endtask

  task automatic test_reset_midload();
    pulse_start();
    send_hdr(16'h0001, 0);
    send_byte(8'h0D, 0);
    send_byte(8'hF0, 0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({rx_ready0, mem_we0, busy0, done0, err0, cpu_run0, mem_a0, mem_d0, word_cnt0} !== 61'b0) begin
      fails++;
      $display("[TB] FAIL async_reset rdy=%b busy=%b run=%b a=%h d=%h cnt=%0d required all 0",
               rx_ready0, busy0, cpu_run0, mem_a0, mem_d0, word_cnt0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    pulse_start();
    send_hdr(16'h0001, 0);
    send_word(32'hCAFEF00D, 0);
    tests++;
    if (mem_we0 !== 1'b1 || mem_a0 !== 11'd0 || mem_d0 !== 32'hCAFEF00D) begin
      fails++;
      $display("[TB] FAIL rerun_word we=%b a=%0d d=%h required 1 0 cafef00d", mem_we0, mem_a0, mem_d0);
    end
    send_chk();
    wait_finish();
    tests++;
    if (done0 !== 1'b1 || cpu_run0 !== 1'b1 || word_cnt0 !== 12'd1) begin
      fails++;
      $display("[TB] FAIL rerun_done done=%b run=%b cnt=%0d required 1 1 1", done0, cpu_run0, word_cnt0);
    end
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum();
    pulse_start();
    send_hdr(16'h0001, 0);
    send_word(32'h04030201, 0);
    send_byte(8'h04, 0);
    tests++;
    if (done0 !== 1'b1 || err0 !== 1'b0 || cpu_run0 !== 1'b1) begin
      fails++;
      $display("[TB] FAIL chk_good done=%b err=%b run=%b required 1 0 1", done0, err0, cpu_run0);
    end
    pulse_start();
    send_hdr(16'h0001, 0);
    send_word(32'h04030201, 0);
    send_byte(8'h05, 0);
    tests++;
    if (err0 !== 1'b1 || done0 !== 1'b0 || cpu_run0 !== 1'b0) begin
      fails++;
      $display("[TB] FAIL chk_bad err=%b done=%b run=%b required 1 0 0", err0, done0, cpu_run0);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_load();
    test_empty_image();
    test_oversize();
    test_wrap_gaps();
    test_reset_midload();
`ifdef LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog_timeout time=%0t required completion", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
